// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm register bank and its scan sequencer.
package alarm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int unsigned ALARM_WIDTH        = 13;
  localparam int unsigned ALARM_DEPTH        = 7;
  localparam int unsigned ALARM_SNOOZE_TICKS = 5;

endpackage

// File: rtl/alarm_scan_fsm.sv
// Scan sequencer: walks idx 0..DEPTH-1 once per Tick, queues one pending Tick
// and flags Overrun when a further Tick arrives while one is already queued.
module alarm_scan_fsm
  import alarm_pkg::*;
#(
  parameter int unsigned DEPTH = ALARM_DEPTH,
  parameter int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [SEL_W-1:0] idx,
  output logic             busy,
  output logic             overrun
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  scan_state_e state;
  logic        pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) begin
            // The pending Tick is consumed by the restart, so a Tick landing
            // on the last compare simply becomes (or stays) the next pending one.
            if (pending || tick) begin
              idx     <= '0;
              pending <= pending && tick;
            end else begin
              state <= IDLE;
              idx   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            idx <= idx + 1'b1;
            if (tick) begin
              if (pending) overrun <= 1'b1;
              else         pending <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_register_bank.sv
// DEPTH-entry alarm store with sequential Time compare per Tick.
// Optional snooze re-fire is built when ALARM_SNOOZE_EN is defined.
module alarm_register_bank
  import alarm_pkg::*;
#(
  parameter int unsigned WIDTH = ALARM_WIDTH,
  parameter int unsigned DEPTH = ALARM_DEPTH,
  parameter int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
`ifdef ALARM_SNOOZE_EN
  ,
  parameter int unsigned SNOOZE_TICKS = ALARM_SNOOZE_TICKS
`endif
) (
  input  logic                   Clock,
  input  logic                   Clear,
  input  logic                   Enable,
  input  logic                   Disarm,
  input  logic [SEL_W-1:0]       STO,
  input  logic [WIDTH-1:0]       D,
  input  logic [WIDTH-1:0]       Time,
  input  logic                   Tick,
`ifdef ALARM_SNOOZE_EN
  input  logic                   Snooze,
`endif
  output logic [DEPTH*WIDTH-1:0] Q_flat,
  output logic [DEPTH-1:0]       Valid,
  output logic                   Hit,
  output logic [SEL_W-1:0]       Hit_idx,
  output logic                   Busy,
  output logic                   Overrun
);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [SEL_W-1:0] scan_idx;
  logic             sto_ok;
  logic             match;

  assign sto_ok = (32'(STO) < DEPTH);
  assign match  = Busy && Valid[scan_idx] && (entries[scan_idx] == Time);

  alarm_scan_fsm #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_scan (
    .clk     (Clock),
    .rst     (Clear),
    .tick    (Tick),
    .idx     (scan_idx),
    .busy    (Busy),
    .overrun (Overrun)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      Valid <= '0;
    end else if (sto_ok) begin
      if (Enable) begin
        entries[STO] <= D;
        Valid[STO]   <= 1'b1;
      end else if (Disarm) begin
        Valid[STO] <= 1'b0;
      end
    end
  end

  always_comb begin
    Q_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) Q_flat[i*WIDTH +: WIDTH] = entries[i];
  end

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned CNT_W = $clog2(SNOOZE_TICKS + 1);

  logic [SEL_W-1:0] last_idx;
  logic [SEL_W-1:0] snz_idx;
  logic [CNT_W-1:0] snz_cnt;
  logic             have_hit;
  logic             snz_armed;
  logic             snz_load;
  logic             snz_cancel;
  logic             snz_fire;

  assign snz_load   = Snooze && (Hit || have_hit);
  assign snz_cancel = snz_armed && Disarm && !Enable && sto_ok && (STO == snz_idx);
  assign snz_fire   = snz_armed && Tick && (snz_cnt == CNT_W'(1)) && !snz_load && !snz_cancel;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      last_idx  <= '0;
      snz_idx   <= '0;
      snz_cnt   <= '0;
      have_hit  <= 1'b0;
      snz_armed <= 1'b0;
    end else begin
      if (Hit) begin
        last_idx <= Hit_idx;
        have_hit <= 1'b1;
      end
      if (snz_load) begin
        snz_idx   <= Hit ? Hit_idx : last_idx;
        snz_cnt   <= CNT_W'(SNOOZE_TICKS);
        snz_armed <= 1'b1;
      end else if (snz_cancel) begin
        snz_armed <= 1'b0;
      end else if (snz_armed && Tick) begin
        snz_cnt <= snz_cnt - 1'b1;
        if (snz_cnt == CNT_W'(1)) snz_armed <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Hit     <= 1'b0;
      Hit_idx <= '0;
    end else if (match) begin
      Hit     <= 1'b1;
      Hit_idx <= scan_idx;
`ifdef ALARM_SNOOZE_EN
    // A back-to-back scan's last compare owns this slot; the re-fire yields to it.
    end else if (snz_fire) begin
      Hit     <= 1'b1;
      Hit_idx <= snz_idx;
`endif
    end else begin
      Hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_register_bank.sv
// Randomized and directed bench for alarm_register_bank against a scan-schedule
// reference model; the snooze re-fire case is exercised when ALARM_SNOOZE_EN is defined.
module tb_alarm_register_bank;

  localparam int WIDTH = 13;
  localparam int DEPTH = 7;
  localparam int SEL_W = 3;

  logic                   Clock = 1'b0;
  logic                   Clear = 1'b0;
  logic                   Enable = 1'b0;
  logic                   Disarm = 1'b0;
  logic [SEL_W-1:0]       STO = '0;
  logic [WIDTH-1:0]       D = '0;
  logic [WIDTH-1:0]       Time = '0;
  logic                   Tick = 1'b0;
`ifdef ALARM_SNOOZE_EN
  logic                   Snooze = 1'b0;
`endif
  logic [DEPTH*WIDTH-1:0] Q_flat;
  logic [DEPTH-1:0]       Valid;
  logic                   Hit;
  logic [SEL_W-1:0]       Hit_idx;
  logic                   Busy;
  logic                   Overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

`ifdef ALARM_SNOOZE_EN
  alarm_register_bank #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .SNOOZE_TICKS (2)
  ) dut (
    .Clock (Clock), .Clear (Clear), .Enable (Enable), .Disarm (Disarm),
    .STO (STO), .D (D), .Time (Time), .Tick (Tick), .Snooze (Snooze),
    .Q_flat (Q_flat), .Valid (Valid), .Hit (Hit), .Hit_idx (Hit_idx),
    .Busy (Busy), .Overrun (Overrun)
  );
`else
  alarm_register_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .Clock (Clock), .Clear (Clear), .Enable (Enable), .Disarm (Disarm),
    .STO (STO), .D (D), .Time (Time), .Tick (Tick),
    .Q_flat (Q_flat), .Valid (Valid), .Hit (Hit), .Hit_idx (Hit_idx),
    .Busy (Busy), .Overrun (Overrun)
  );
`endif

  // Reference model: a scan started at edge s compares entry i at edge s+1+i.
  logic [WIDTH-1:0] m_entry [DEPTH];
  logic             m_valid [DEPTH];
  int               edge_n;
  int               s_start;
  bit               scan_act;
  bit               m_pend;
  bit               m_ovr;
  bit               exp_hit;
  int               exp_idx;
  bit               exp_busy;
  bit               model_en = 1'b1;

  always @(posedge Clock) begin
    if (Clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_entry[i] = '0;
        m_valid[i] = 1'b0;
      end
      edge_n = 0; s_start = 0; scan_act = 0; m_pend = 0; m_ovr = 0;
      exp_hit = 0; exp_idx = 0; exp_busy = 0;
    end else begin
      exp_hit = 0;
      if (scan_act && edge_n > s_start && edge_n <= s_start + DEPTH) begin
        if (m_valid[edge_n - s_start - 1] && m_entry[edge_n - s_start - 1] == Time) begin
          exp_hit = 1;
          exp_idx = edge_n - s_start - 1;
        end
      end
      if (Tick) begin
        if (!scan_act || edge_n > s_start + DEPTH) begin
          s_start = edge_n; scan_act = 1;
        end else if (edge_n == s_start + DEPTH) begin
          s_start = edge_n;
        end else if (m_pend) begin
          m_ovr = 1;
        end else begin
          m_pend = 1;
        end
      end else if (scan_act && edge_n == s_start + DEPTH && m_pend) begin
        s_start = edge_n; m_pend = 0;
      end
      if (int'(STO) < DEPTH) begin
        if (Enable) begin
          m_entry[STO] = D;
          m_valid[STO] = 1'b1;
        end else if (Disarm) begin
          m_valid[STO] = 1'b0;
        end
      end
      exp_busy = scan_act && edge_n >= s_start && edge_n < s_start + DEPTH;
      edge_n++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [DEPTH*WIDTH-1:0] q;
    logic [DEPTH-1:0]       v;
    if (!model_en) return;
    for (int i = 0; i < DEPTH; i++) begin
      q[i*WIDTH +: WIDTH] = m_entry[i];
      v[i] = m_valid[i];
    end
    check("hit", 128'(Hit), 128'(exp_hit));
    if (exp_hit) check("hit_idx", 128'(Hit_idx), 128'(exp_idx));
    check("busy", 128'(Busy), 128'(exp_busy));
    check("overrun", 128'(Overrun), 128'(m_ovr));
    check("valid", 128'(Valid), 128'(v));
    check("q_flat", 128'(Q_flat), 128'(q));
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    check_model();
  endtask

  task automatic write_entry(input int sto, input logic [WIDTH-1:0] d);
    Enable = 1'b1; STO = SEL_W'(sto); D = d;
    step();
    Enable = 1'b0;
  endtask

  task automatic disarm_entry(input int sto);
    Disarm = 1'b1; STO = SEL_W'(sto);
    step();
    Disarm = 1'b0;
  endtask

  task automatic pulse_tick();
    Tick = 1'b1;
    step();
    Tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  logic [WIDTH-1:0] vals [4] = '{13'h123, 13'h0FF, 13'h055, 13'h000};

  initial begin
    @(negedge Clock);
    // Clear asserted during a write: nothing stored.
    Enable = 1'b1; STO = 3'd2; D = 13'h0FF;
    do_clear();
    Enable = 1'b0;
    check("reset_hit_idx", 128'(Hit_idx), 128'(0));
    check("reset_valid", 128'(Valid), 128'(0));

    write_entry(2, 13'h0FF);
    check("valid_sto2", 128'(Valid), 128'(7'b0000100));

    write_entry(1, 13'h123);
    write_entry(4, 13'h123);
    Time = 13'h123;
    pulse_tick();
    idle(8);

    disarm_entry(4);
    write_entry(7, 13'h1FFF);
    pulse_tick();
    idle(8);

    // Tick, pending Tick at +3, lost Tick at +4.
    pulse_tick();
    idle(2);
    pulse_tick();
    pulse_tick();
    check("overrun_set", 128'(Overrun), 128'(1));
    idle(16);
    check("overrun_sticky", 128'(Overrun), 128'(1));

    // Write/compare collision on entry 3.
    do_clear();
    check("overrun_cleared", 128'(Overrun), 128'(0));
    write_entry(3, 13'h000);
    Time = 13'h055;
    pulse_tick();
    idle(3);
    write_entry(3, 13'h055);
    idle(5);
    pulse_tick();
    idle(8);

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_clear();
      end else begin
        Tick   = ($urandom_range(0, 4) == 0);
        Enable = ($urandom_range(0, 5) == 0);
        Disarm = ($urandom_range(0, 7) == 0);
        STO    = SEL_W'($urandom_range(0, 7));
        D      = vals[$urandom_range(0, 3)];
        if (!Busy && $urandom_range(0, 3) == 0) Time = vals[$urandom_range(0, 3)];
        step();
        Tick = 1'b0; Enable = 1'b0; Disarm = 1'b0;
      end
    end
    idle(20);

`ifdef ALARM_SNOOZE_EN
    begin
      int waited;
      model_en = 1'b0;
      do_clear();
      write_entry(1, 13'h123);
      Time = 13'h123;
      pulse_tick();
      step();
      check("snz_first_hit", 128'(Hit), 128'(1));
      check("snz_first_idx", 128'(Hit_idx), 128'(1));
      Snooze = 1'b1;
      step();
      Snooze = 1'b0;
      Time = 13'h000;
      waited = 0;
      while (Busy && waited < 20) begin step(); waited++; end
      check("snz_wait1", 128'(Busy), 128'(0));
      pulse_tick();
      check("snz_no_fire_early", 128'(Hit), 128'(0));
      waited = 0;
      while (Busy && waited < 20) begin step(); waited++; end
      check("snz_wait2", 128'(Busy), 128'(0));
      pulse_tick();
      check("snz_refire", 128'(Hit), 128'(1));
      check("snz_refire_idx", 128'(Hit_idx), 128'(1));
      step();
      check("snz_single_pulse", 128'(Hit), 128'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_register_bank.md
# alarm_register_bank

Parametrised successor of the seven-entry alarm register module. It stores DEPTH alarm times of WIDTH bits, each with a valid (armed) flag. On every time tick it scans all entries sequentially and pulses a hit for each armed entry that equals the current time. It sits between the time-setting front end, which writes entries, and the alarm sounder, which consumes hits.

## Interface
Parameters:
- WIDTH, 13, bits per stored alarm time (same encoding as the time counter)
- DEPTH, 7, number of alarm entries, 1..16
- SEL_W, $clog2(DEPTH) (min 1), width of entry select/index

Ports:
- Clock  in  1  single clock; all state on rising edge
- Clear  in  1  asynchronous, active-high reset
- Enable  in  1  write strobe; writes D into entry STO and arms it
- Disarm  in  1  clears valid of entry STO; loses to Enable when both are high
- STO  in  SEL_W  entry select for write/disarm
- D  in  WIDTH  write data
- Time  in  WIDTH  current time, stable from Tick through end of scan
- Tick  in  1  one-cycle pulse: time advanced, start scan
- Q_flat  out  DEPTH*WIDTH  all stored entries, entry i at [i*WIDTH +: WIDTH]
- Valid  out  DEPTH  armed flags
- Hit  out  1  one-cycle pulse per matching entry
- Hit_idx  out  SEL_W  index of matching entry, meaningful only while Hit=1
- Busy  out  1  scan in progress
- Overrun  out  1  sticky; Tick lost (second Tick while one already pending)

## Operation
- Reset: every entry = 0, Valid = 0, Hit = 0, Hit_idx = 0, Busy = 0, Overrun = 0, FSM = IDLE. Clear mid-scan aborts the scan immediately with no further Hit.
- Write: Enable with STO<DEPTH → entry[STO] <= D, Valid[STO] <= 1 at the next edge. STO>=DEPTH → ignored, no state change. Disarm behaves the same way but only clears Valid.
- FSM states:
  - IDLE: on Tick → SCAN, idx = 0.
  - SCAN: compare entry[idx] against Time; idx increments each cycle. At idx = DEPTH-1, go to IDLE, or restart SCAN at idx 0 if a Tick is pending.
- Pending: one Tick received during SCAN is latched and served next. A further Tick while one is already pending sets Overrun.
- Match: Valid[idx] && entry[idx]==Time. The match is registered into Hit/Hit_idx. Several entries may hit in one scan, giving consecutive pulses in ascending index order.
- Write/scan collision: the compare uses the value stored before the edge. A write to the entry being compared affects only later scans.

## Timing
- Tick sampled at edge t → Busy = 1 from t+1.
- Entry i compared during cycle t+1+i → its Hit appears in cycle t+2+i.
- Busy falls after cycle t+DEPTH unless a pending scan restarts back-to-back with no gap.
- Write-to-Q_flat/Valid latency: 1 cycle.
- Tick in the same cycle the last compare executes counts as pending, not lost.

## Configuration
- ALARM_SNOOZE_EN defined:
  - Adds input Snooze (1) and parameter SNOOZE_TICKS (default 5).
  - Snooze within the cycle of or after a Hit captures the last Hit_idx and loads a tick counter.
  - Each Tick decrements the counter; at zero a Hit re-fires for that index in the cycle before that scan's first compare hit slot (cycle t+1), regardless of Time match.
  - A new Snooze reloads the counter. Disarm of the snoozed entry cancels the snooze.
- Undefined: no Snooze port, no counter, hits only from Time matches.

## Structure
- Shared package alarm_pkg: FSM state enum (IDLE, SCAN), default WIDTH/DEPTH constants, SNOOZE_TICKS default.
- One sub-module alarm_scan_fsm: IDLE/SCAN state, idx counter, pending/Overrun logic, Busy. Storage, compare and Hit registers stay in the top module.

## Test plan
- Clear asserted mid-write: all Q_flat=0, Valid=0, no Hit afterwards. Write D=13'h0FF to STO=2 → Valid=7'b0000100 next cycle.
- Entries 1 and 4 = 13'h123, armed, Time=13'h123, Tick at t → Hit at t+3 (idx 1) and t+6 (idx 4), Busy for 7 cycles.
- Disarm entry 4, same Tick → single Hit idx 1. STO=7 write → no change.
- Tick at t and t+3 → second scan starts t+8 back-to-back. Third Tick at t+4 → Overrun=1, sticky until Clear.
- Write entry 3 with the matching value in cycle t+4 (entry 3's compare cycle, old value nonmatching) → no hit this scan, hit on the next scan.
- ALARM_SNOOZE_EN: Hit idx 1 then Snooze, SNOOZE_TICKS=2 → re-fire Hit idx 1 on the second following Tick with Time ≠ entry.
